// File: rtl/neopix_bit_encoder.sv
// WS2812 single-wire encoder: shifts 24-bit GRB pixels out MSB first, then holds DO low
// for the strip latch gap after the pixel flagged last. Optional: NEOPIX_BRIGHTNESS_EN.
module neopix_bit_encoder #(
  parameter int unsigned T_BIT   = 62,
  parameter int unsigned T0H     = 20,
  parameter int unsigned T1H     = 40,
  parameter int unsigned T_LATCH = 15000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_LAST,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic [7:0]  BRIGHT,
  output logic        DO,
  output logic        BUSY,
  output logic        UNDERRUN
);

  localparam int unsigned PW = $clog2(T_BIT);
  localparam int unsigned LW = $clog2(T_LATCH + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(T_BIT - 1);
  localparam logic [PW-1:0] PH_T0H     = PW'(T0H);
  localparam logic [PW-1:0] PH_T1H     = PW'(T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(T_LATCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [LW-1:0] latch_cnt_q, latch_cnt_d;
  logic          last_q, last_d;
  logic          do_q, do_d;
  logic          underrun_q, underrun_d;

  logic [23:0]   load_data;
  logic          bit_end;
  logic          boundary;
  logic          accept;

`ifdef NEOPIX_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction

  assign load_data = {scale(PIX_DATA[23:16], BRIGHT),
                      scale(PIX_DATA[15:8],  BRIGHT),
                      scale(PIX_DATA[7:0],   BRIGHT)};
`else
  logic unused_bright;
  assign unused_bright = ^BRIGHT;
  assign load_data     = PIX_DATA;
`endif

  assign bit_end   = (state_q == S_SEND) && (phase_q == PH_LAST);
  assign boundary  = bit_end && (bit_idx_q == '0);
  assign PIX_READY = !RESET && ((state_q == S_IDLE) || (boundary && !last_q));
  assign accept    = PIX_VALID && PIX_READY;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    phase_d     = phase_q;
    latch_cnt_d = latch_cnt_q;
    last_d      = last_q;
    underrun_d  = 1'b0;

    // Acceptance only happens in IDLE or at a pixel boundary, so it covers both load paths.
    if (accept) begin
      shift_d   = load_data;
      last_d    = PIX_LAST;
      bit_idx_d = 5'd23;
      phase_d   = '0;
      state_d   = S_SEND;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_SEND: begin
          if (!bit_end) begin
            phase_d = phase_q + 1'b1;
          end else if (bit_idx_q != '0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 1'b1;
            phase_d   = '0;
          end else if (last_q) begin
            state_d     = S_LATCH;
            latch_cnt_d = '0;
          end else begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
          end
        end
        S_LATCH: begin
          if (latch_cnt_q == LATCH_LAST) state_d = S_IDLE;
          else                            latch_cnt_d = latch_cnt_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // DO is registered from the next-state view so the line never glitches.
    do_d = 1'b0;
    if (state_d == S_SEND)
      do_d = shift_d[23] ? (phase_d < PH_T1H) : (phase_d < PH_T0H);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      phase_q     <= '0;
      latch_cnt_q <= '0;
      last_q      <= 1'b0;
      do_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      phase_q     <= phase_d;
      latch_cnt_q <= latch_cnt_d;
      last_q      <= last_d;
      do_q        <= do_d;
      underrun_q  <= underrun_d;
    end
  end

  assign DO       = do_q;
  assign UNDERRUN = underrun_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_neopix_bit_encoder.sv
// Scoreboard bench for neopix_bit_encoder: a timeline model predicts each pixel's start cycle,
// bits and end behaviour; a monitor decodes DO pulse widths and compares.
module tb_neopix_bit_encoder;

  localparam int T_BIT   = 62;
  localparam int T0H     = 20;
  localparam int T1H     = 40;
  localparam int T_LATCH = 15000;
  localparam int PIX_CYC = 24 * T_BIT;
`ifdef NEOPIX_BRIGHTNESS_EN
  localparam bit BRIGHT_EN = 1'b1;
`else
  localparam bit BRIGHT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET;
  logic [23:0] PIX_DATA;
  logic        PIX_LAST;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [7:0]  BRIGHT;
  logic        DO;
  logic        BUSY;
  logic        UNDERRUN;

  neopix_bit_encoder #(
    .T_BIT  (T_BIT),
    .T0H    (T0H),
    .T1H    (T1H),
    .T_LATCH(T_LATCH)
  ) dut (
    .CLK      (clk),
    .RESET    (RESET),
    .PIX_DATA (PIX_DATA),
    .PIX_LAST (PIX_LAST),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .BRIGHT   (BRIGHT),
    .DO       (DO),
    .BUSY     (BUSY),
    .UNDERRUN (UNDERRUN)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          start;
    logic [23:0] data;
    logic        last;
    logic        und;
  } rec_t;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic [7:0]  br;
    int          dly;
  } item_t;

  rec_t  exp_q[$];
  item_t items[$];

  int total = 0;
  int bad = 0;
  int und_seen = 0;
  int und_exp = 0;
  int rst_cyc = -10;
  bit mon_en = 1'b0;
  bit timed_out = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [23:0] expect_px(input logic [23:0] d, input logic [7:0] b);
    int g, r, bl;
    g  = (int'(d[23:16]) * (int'(b) + 1)) / 256;
    r  = (int'(d[15:8])  * (int'(b) + 1)) / 256;
    bl = (int'(d[7:0])   * (int'(b) + 1)) / 256;
    return BRIGHT_EN ? {8'(g), 8'(r), 8'(bl)} : d;
  endfunction

  task automatic present(input logic [23:0] d, input logic l, input logic [7:0] b, input int a_exp);
    int acc;
    PIX_DATA  = d;
    PIX_LAST  = l;
    BRIGHT    = b;
    PIX_VALID = 1'b1;
    acc = -1;
    for (int n = 0; n < PIX_CYC + T_LATCH + 100; n++) begin
      @(negedge clk);
      if (PIX_READY === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      total++;
      bad++;
      timed_out = 1'b1;
      $display("FAIL accept_timeout: got no handshake required accept at %0d", a_exp);
    end else begin
      chk("accept_cycle", acc, a_exp);
    end
    @(posedge clk);
    #1;
    PIX_VALID = 1'b0;
  endtask

  // Monitor: decode DO pulses into bits and check pixel, end-of-pixel and latch behaviour.
  rec_t        cur, end_rec;
  bit          active = 1'b0, end_pending = 1'b0, tim_ok;
  logic        prev_do = 1'b0;
  logic [23:0] word;
  int          k, rise_c, len, end_cyc, lat_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cyc == rst_cyc + 1) begin
          chk("rst_mid_do", DO, 0);
          chk("rst_mid_busy", BUSY, 0);
          chk("rst_mid_ready", PIX_READY, 1);
          active = 1'b0;
          end_pending = 1'b0;
          lat_cyc = -1;
        end else begin
          if (DO === 1'b1 && prev_do === 1'b0) begin
            if (!active) begin
              chk("pulse_has_record", exp_q.size() != 0, 1);
              if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                active = 1'b1;
                k = 0;
                word = '0;
                tim_ok = 1'b1;
              end
            end
            if (active) begin
              if (cyc != cur.start + k * T_BIT) tim_ok = 1'b0;
              rise_c = cyc;
            end
          end
          if (DO === 1'b0 && prev_do === 1'b1 && active) begin
            len = cyc - rise_c;
            if (len != T0H && len != T1H) tim_ok = 1'b0;
            word = {word[22:0], (len > (T0H + T1H) / 2) ? 1'b1 : 1'b0};
            k++;
            if (k == 24) begin
              chk("pixel_bits", word, cur.data);
              chk("pixel_timing", tim_ok, 1);
              active = 1'b0;
              end_pending = 1'b1;
              end_rec = cur;
              end_cyc = cur.start + PIX_CYC;
            end
          end
          if (end_pending && cyc == end_cyc) begin
            chk("end_underrun", UNDERRUN, end_rec.und);
            chk("end_busy", BUSY, !end_rec.und);
            if (end_rec.last) lat_cyc = end_cyc + T_LATCH;
            end_pending = 1'b0;
          end
          if (lat_cyc >= 0 && cyc == lat_cyc - 1) begin
            chk("latch_busy", BUSY, 1);
            chk("latch_ready", PIX_READY, 0);
            chk("latch_do", DO, 0);
          end
          if (lat_cyc >= 0 && cyc == lat_cyc) begin
            chk("latch_done_busy", BUSY, 0);
            chk("latch_done_ready", PIX_READY, 1);
            lat_cyc = -1;
          end
        end
        if (UNDERRUN === 1'b1) und_seen++;
        prev_do = DO;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1);
  end

  initial begin
    int   p, a, b_end, free, prev_b, next_p;
    bit   have_prev, prev_last, und;
    rec_t r;
    logic [23:0] rd;
    logic [7:0]  rb;

    RESET = 1'b1; PIX_VALID = 1'b0; PIX_DATA = '0; PIX_LAST = 1'b0; BRIGHT = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do", DO, 0);
    chk("rst_ready", PIX_READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_underrun", UNDERRUN, 0);
    @(posedge clk);
    #1;
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_ready", PIX_READY, 1);
    @(posedge clk);
    #1;

    items.push_back('{24'hFF0000, 1'b1, 8'hFF, 0});
    items.push_back('{24'hAA55F0, 1'b0, 8'hFF, 0});
    items.push_back('{24'h000001, 1'b0, 8'h00, 0});
    items.push_back('{24'h800000, 1'b1, 8'hFF, 0});
    items.push_back('{24'h123456, 1'b0, 8'hFF, 0});
    items.push_back('{24'hFF8040, 1'b0, 8'h7F, PIX_CYC + 112});
    items.push_back('{24'hFF8040, 1'b0, 8'hFF, 5});
    for (int i = 0; i < 10; i++) begin
      int sel, d;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       d = 0;
        1, 2:    d = int'($urandom_range(1, 300));
        3:       d = PIX_CYC - 1;
        4:       d = PIX_CYC;
        default: d = int'($urandom_range(PIX_CYC, PIX_CYC + 40));
      endcase
      items.push_back('{24'($urandom), 1'b0, 8'($urandom), d});
    end

    have_prev = 1'b0; prev_last = 1'b0; prev_b = 0; free = cyc;
    for (int i = 0; i < items.size(); i++) begin
      if (timed_out) break;
      repeat (items[i].dly) begin
        @(posedge clk);
        #1;
      end
      p = cyc;
      if (have_prev && !prev_last && p <= prev_b) a = prev_b;
      else a = (p > free) ? p : free;
      b_end = a + PIX_CYC;
      next_p = (i + 1 < items.size()) ? a + 1 + items[i + 1].dly : b_end + 1;
      und = !items[i].last && (next_p > b_end);
      r.start = a + 1;
      r.data  = expect_px(items[i].data, items[i].br);
      r.last  = items[i].last;
      r.und   = und;
      exp_q.push_back(r);
      if (und) und_exp++;
      present(items[i].data, items[i].last, items[i].br, a);
      have_prev = 1'b1;
      prev_last = items[i].last;
      prev_b    = b_end;
      free      = items[i].last ? b_end + 1 + T_LATCH : b_end + 1;
    end

    if (!timed_out) begin
      while (cyc < prev_b + 10) begin
        @(posedge clk);
        #1;
      end
      p = cyc;
      a = (p > free) ? p : free;
      rd = 24'($urandom); rb = 8'($urandom);
      r.start = a + 1; r.data = expect_px(rd, rb); r.last = 1'b1; r.und = 1'b0;
      exp_q.push_back(r);
      present(rd, 1'b1, rb, a);
      while (cyc < a + 1 + 5 * T_BIT + 10) begin
        @(posedge clk);
        #1;
      end
      RESET = 1'b1;
      rst_cyc = cyc;
      @(posedge clk);
      #1;
      RESET = 1'b0;
      a = cyc;
      rd = 24'($urandom); rb = 8'($urandom);
      r.start = a + 1; r.data = expect_px(rd, rb); r.last = 1'b0; r.und = 1'b1;
      exp_q.push_back(r);
      und_exp++;
      present(rd, 1'b0, rb, a);
    end

    for (int n = 0; n < PIX_CYC + 200; n++) begin
      if (exp_q.size() == 0 && !active && !end_pending) break;
      @(posedge clk);
    end
    chk("drained", (exp_q.size() == 0 && !active && !end_pending), 1);
    repeat (3) @(posedge clk);
    chk("underrun_count", und_seen, und_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
